// File: rtl/assert_report_arbiter.sv
// Round-robin arbiter that funnels assertion-monitor failure pulses into one valid/ready report port.
// Optional per-report timestamps are compiled in with ASSERT_REPORT_ARBITER_TIMESTAMP_EN.
module assert_report_arbiter #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned ID_W  = 2,
   parameter int unsigned CNT_W = 16
`ifdef ASSERT_REPORT_ARBITER_TIMESTAMP_EN
   ,
   parameter int unsigned TS_W  = 32
`endif
) (
   input  logic             CLK,
   input  logic             RESETN,
   input  logic [N_REQ-1:0] fail_i,
   output logic             rpt_valid,
   input  logic             rpt_ready,
   output logic [ID_W-1:0]  rpt_id,
   output logic             rpt_overrun,
`ifdef ASSERT_REPORT_ARBITER_TIMESTAMP_EN
   output logic [TS_W-1:0]  rpt_ts,
`endif
   output logic [N_REQ-1:0] pending,
   output logic [CNT_W-1:0] fail_count,
   output logic             first_valid,
   output logic [ID_W-1:0]  first_id
);

   logic             r_rpt_valid;
   logic [ID_W-1:0]  r_rpt_id;
   logic             r_rpt_overrun;
   logic [N_REQ-1:0] r_pending;
   logic [N_REQ-1:0] r_overrun;
   logic [ID_W-1:0]  r_ptr;
   logic [CNT_W-1:0] r_fail_count;
   logic             r_first_valid;
   logic [ID_W-1:0]  r_first_id;

   logic [N_REQ-1:0] w_req;
   logic             w_slot_free;
   logic             w_gnt_vld;
   logic             w_grant;
   logic [ID_W-1:0]  w_gnt_idx;
   logic [ID_W:0]    w_sum_idx;
   logic [ID_W-1:0]  w_idx;
   logic [N_REQ-1:0] w_gnt_oh;
   logic             w_gnt_ovr;
   logic [ID_W-1:0]  w_ptr_nxt;
   logic [N_REQ-1:0] w_pending_d;
   logic [N_REQ-1:0] w_overrun_d;
   logic [4:0]       w_popcnt;
   logic [CNT_W:0]   w_cnt_sum;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [ID_W-1:0]  w_first_idx;

   assign w_req       = r_pending | fail_i;
   assign w_slot_free = !r_rpt_valid || rpt_ready;

   // Search from r_ptr upward, wrapping modulo N_REQ (which need not be a power of two).
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt_idx = '0;
      w_sum_idx = '0;
      w_idx     = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         w_sum_idx = {1'b0, r_ptr} + (ID_W+1)'(k);
         if (w_sum_idx >= (ID_W+1)'(N_REQ)) begin
            w_sum_idx = w_sum_idx - (ID_W+1)'(N_REQ);
         end
         w_idx = w_sum_idx[ID_W-1:0];
         if (!w_gnt_vld && w_req[w_idx]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = w_idx;
         end
      end
   end

   assign w_grant   = w_gnt_vld && w_slot_free;
   assign w_gnt_oh  = w_grant ? (N_REQ'(1) << w_gnt_idx) : '0;
   assign w_gnt_ovr = r_overrun[w_gnt_idx] | (r_pending[w_gnt_idx] & fail_i[w_gnt_idx]);
   assign w_ptr_nxt = (w_gnt_idx == ID_W'(N_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;

   // A fresh fail on an already-pending granted index survives as a new pending event.
   assign w_pending_d = (w_req & ~w_gnt_oh) | (w_gnt_oh & r_pending & fail_i);
   assign w_overrun_d = (r_overrun | (r_pending & fail_i)) & ~w_gnt_oh;

   always_comb begin
      w_popcnt = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         w_popcnt = w_popcnt + 5'(fail_i[i]);
      end
   end

   assign w_cnt_sum = {1'b0, r_fail_count} + (CNT_W+1)'(w_popcnt);
   assign w_cnt_nxt = w_cnt_sum[CNT_W] ? {CNT_W{1'b1}} : w_cnt_sum[CNT_W-1:0];

   always_comb begin
      w_first_idx = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (fail_i[i]) begin
            w_first_idx = ID_W'(i);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         r_rpt_valid   <= 1'b0;
         r_rpt_id      <= '0;
         r_rpt_overrun <= 1'b0;
         r_pending     <= '0;
         r_overrun     <= '0;
         r_ptr         <= '0;
         r_fail_count  <= '0;
         r_first_valid <= 1'b0;
         r_first_id    <= '0;
      end else begin
         r_pending    <= w_pending_d;
         r_overrun    <= w_overrun_d;
         r_fail_count <= w_cnt_nxt;
         if (w_slot_free) begin
            r_rpt_valid <= w_gnt_vld;
         end
         if (w_grant) begin
            r_rpt_id      <= w_gnt_idx;
            r_rpt_overrun <= w_gnt_ovr;
            r_ptr         <= w_ptr_nxt;
         end
         if (!r_first_valid && (|fail_i)) begin
            r_first_valid <= 1'b1;
            r_first_id    <= w_first_idx;
         end
      end
   end

`ifdef ASSERT_REPORT_ARBITER_TIMESTAMP_EN
   logic [TS_W-1:0] r_cyc;
   logic [TS_W-1:0] r_rpt_ts;
   logic [TS_W-1:0] r_ts [N_REQ];

   // Timestamp is captured only when an index goes from idle to pending; merged fails keep it.
   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         r_cyc    <= '0;
         r_rpt_ts <= '0;
         for (int i = 0; i < N_REQ; i++) begin
            r_ts[i] <= '0;
         end
      end else begin
         r_cyc <= r_cyc + 1'b1;
         if (w_grant) begin
            r_rpt_ts <= r_pending[w_gnt_idx] ? r_ts[w_gnt_idx] : r_cyc;
         end
         for (int i = 0; i < N_REQ; i++) begin
            if (fail_i[i] && (w_gnt_oh[i] ? r_pending[i] : !r_pending[i])) begin
               r_ts[i] <= r_cyc;
            end
         end
      end
   end

   assign rpt_ts = r_rpt_ts;
`endif

   assign rpt_valid   = r_rpt_valid;
   assign rpt_id      = r_rpt_id;
   assign rpt_overrun = r_rpt_overrun;
   assign pending     = r_pending;
   assign fail_count  = r_fail_count;
   assign first_valid = r_first_valid;
   assign first_id    = r_first_id;

endmodule

// File: tb/tb_assert_report_arbiter.sv
// Bench for assert_report_arbiter: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against a behavioural model.
module tb_assert_report_arbiter;

   localparam int N  = 4;
   localparam int IW = 2;
   localparam int CW = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk  = 1'b0;
   logic          rstn = 1'b0;
   logic [N-1:0]  fail = '0;
   logic          rdy  = 1'b0;
   logic          rpt_valid;
   logic [IW-1:0] rpt_id;
   logic          rpt_overrun;
   logic [N-1:0]  pending;
   logic [CW-1:0] fail_count;
   logic          first_valid;
   logic [IW-1:0] first_id;
`ifdef ASSERT_REPORT_ARBITER_TIMESTAMP_EN
   logic [31:0]   rpt_ts;
`endif

   assert_report_arbiter #(
      .N_REQ (N),
      .ID_W  (IW),
      .CNT_W (CW)
   ) dut (
      .CLK         (clk),
      .RESETN      (rstn),
      .fail_i      (fail),
      .rpt_valid   (rpt_valid),
      .rpt_ready   (rdy),
      .rpt_id      (rpt_id),
      .rpt_overrun (rpt_overrun),
`ifdef ASSERT_REPORT_ARBITER_TIMESTAMP_EN
      .rpt_ts      (rpt_ts),
`endif
      .pending     (pending),
      .fail_count  (fail_count),
      .first_valid (first_valid),
      .first_id    (first_id)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   bit cmp_en   = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: state after each rising edge.
   bit           m_valid;
   int           m_id;
   bit           m_ovr;
   logic [N-1:0] m_pend;
   logic [N-1:0] m_ovf;
   int           m_ptr;
   int           m_cnt;
   bit           m_fv;
   int           m_fid;
   int           m_cyc;
   int           m_ts [N];
   int           m_rts;

   always @(posedge clk) begin : model
      logic [N-1:0] p, o;
      int ts [N];
      int g, idx, c;
      if (!rstn) begin
         m_valid <= 1'b0; m_id <= 0; m_ovr <= 1'b0; m_pend <= '0; m_ovf <= '0;
         m_ptr <= 0; m_cnt <= 0; m_fv <= 1'b0; m_fid <= 0; m_cyc <= 0; m_rts <= 0;
         m_ts <= '{default: 0};
      end else begin
         p = m_pend;
         o = m_ovf;
         ts = m_ts;
         g = -1;
         if (!m_valid || rdy) begin
            for (int k = 0; k < N; k++) begin
               idx = (m_ptr + k) % N;
               if (g < 0 && (m_pend[idx] || fail[idx])) g = idx;
            end
            m_valid <= (g >= 0);
            if (g >= 0) begin
               m_id  <= g;
               m_ovr <= m_ovf[g] || (m_pend[g] && fail[g]);
               m_rts <= m_pend[g] ? m_ts[g] : m_cyc;
               o[g] = 1'b0;
               p[g] = m_pend[g] && fail[g];
               if (p[g]) ts[g] = m_cyc;
               m_ptr <= (g + 1) % N;
            end
         end
         for (int i = 0; i < N; i++) begin
            if (i != g) begin
               if (m_pend[i] && fail[i]) o[i] = 1'b1;
               if (!m_pend[i] && fail[i]) ts[i] = m_cyc;
               p[i] = m_pend[i] || fail[i];
            end
         end
         m_pend <= p;
         m_ovf  <= o;
         m_ts   <= ts;
         c = m_cnt + $countones(fail);
         m_cnt <= (c > CMAX) ? CMAX : c;
         if (!m_fv && fail != 0) begin
            m_fv <= 1'b1;
            for (int i = N - 1; i >= 0; i--) if (fail[i]) m_fid <= i;
         end
         m_cyc <= m_cyc + 1;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("cmp_valid", 32'(rpt_valid), 32'(m_valid));
         if (m_valid) begin
            chk("cmp_id", 32'(rpt_id), m_id);
            chk("cmp_overrun", 32'(rpt_overrun), 32'(m_ovr));
`ifdef ASSERT_REPORT_ARBITER_TIMESTAMP_EN
            chk("cmp_ts", rpt_ts, m_rts);
`endif
         end
         chk("cmp_pending", 32'(pending), 32'(m_pend));
         chk("cmp_count", 32'(fail_count), m_cnt);
         chk("cmp_first_valid", 32'(first_valid), 32'(m_fv));
         if (m_fv) chk("cmp_first_id", 32'(first_id), m_fid);
      end
   end

   // Called at a falling edge; returns at the next falling edge with that edge's outputs.
   task automatic cyc(input logic [N-1:0] f, input logic r);
      fail = f;
      rdy  = r;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      cyc(4'b1111, 1'b0);
      rstn = 1'b1;
   endtask

   int exp_rr [4] = '{0, 1, 0, 1};

   initial begin
      @(negedge clk);
      cyc('0, 1'b0);
      cyc('0, 1'b0);
      rstn = 1'b1;
      chk("reset_valid", 32'(rpt_valid), 0);
      chk("reset_id", 32'(rpt_id), 0);
      chk("reset_overrun", 32'(rpt_overrun), 0);
      chk("reset_pending", 32'(pending), 0);
      chk("reset_count", 32'(fail_count), 0);
      chk("reset_first_valid", 32'(first_valid), 0);
      chk("reset_first_id", 32'(first_id), 0);
      cmp_en = 1'b1;

      // Single fail, direct grant.
      cyc('0, 1'b1);
      cyc('0, 1'b1);
      cyc(4'b0100, 1'b1);
      chk("single_valid", 32'(rpt_valid), 1);
      chk("single_id", 32'(rpt_id), 2);
      chk("single_overrun", 32'(rpt_overrun), 0);
      chk("single_count", 32'(fail_count), 1);
      chk("single_first_valid", 32'(first_valid), 1);
      chk("single_first_id", 32'(first_id), 2);
      cyc('0, 1'b1);
      chk("single_drain", 32'(rpt_valid), 0);

      // Simultaneous fails drain in order 0,1,3.
      do_reset();
      cyc(4'b1011, 1'b1);
      chk("simul_id0", 32'(rpt_id), 0);
      chk("simul_pend0", 32'(pending), 32'b1010);
      chk("simul_count", 32'(fail_count), 3);
      chk("simul_first_id", 32'(first_id), 0);
      chk("model_count", m_cnt, 3);
      cyc('0, 1'b1);
      chk("simul_id1", 32'(rpt_id), 1);
      cyc('0, 1'b1);
      chk("simul_id3", 32'(rpt_id), 3);
      chk("simul_pend_end", 32'(pending), 0);
      cyc('0, 1'b1);
      chk("simul_idle", 32'(rpt_valid), 0);

      // Backpressure with merged fails.
      do_reset();
      cyc(4'b0001, 1'b0);
      chk("bp_valid", 32'(rpt_valid), 1);
      chk("bp_overrun0", 32'(rpt_overrun), 0);
      for (int k = 0; k < 4; k++) begin
         cyc(4'b0001, 1'b0);
         chk("bp_hold_id", 32'(rpt_id), 0);
         chk("bp_hold_valid", 32'(rpt_valid), 1);
      end
      chk("bp_pending", 32'(pending), 1);
      chk("bp_count", 32'(fail_count), 5);
      cyc('0, 1'b1);
      chk("bp_second_valid", 32'(rpt_valid), 1);
      chk("bp_second_id", 32'(rpt_id), 0);
      chk("bp_second_overrun", 32'(rpt_overrun), 1);
      chk("bp_pend_clear", 32'(pending), 0);
      cyc('0, 1'b1);
      chk("bp_idle", 32'(rpt_valid), 0);

      // Round-robin fairness.
      do_reset();
      for (int k = 0; k < 4; k++) begin
         cyc(4'b0011, 1'b1);
         chk("rr_id", 32'(rpt_id), exp_rr[k]);
      end
      cyc('0, 1'b1);
      cyc('0, 1'b1);
      cyc('0, 1'b1);

      // Counter saturation.
      do_reset();
      for (int k = 0; k < 20; k++) begin
         cyc(N'(1 << (k % 4)), 1'b1);
         if (k == 9) chk("sat_count10", 32'(fail_count), 10);
      end
      chk("sat_count", 32'(fail_count), 15);
      chk("model_sat", m_cnt, 15);
      cyc('0, 1'b1);
      cyc('0, 1'b1);

      // Reset during an outstanding report.
      do_reset();
      cyc(4'b0100, 1'b0);
      chk("mid_valid", 32'(rpt_valid), 1);
      do_reset();
      chk("mid_rst_valid", 32'(rpt_valid), 0);
      chk("mid_rst_id", 32'(rpt_id), 0);
      chk("mid_rst_pending", 32'(pending), 0);
      chk("mid_rst_count", 32'(fail_count), 0);
      chk("mid_rst_first", 32'(first_valid), 0);
      cyc(4'b0010, 1'b1);
      chk("post_rst_id", 32'(rpt_id), 1);
`ifdef ASSERT_REPORT_ARBITER_TIMESTAMP_EN
      chk("post_rst_ts", rpt_ts, 0);
`endif

      // Randomized traffic with occasional resets.
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(299) == 0) rstn = 1'b0;
         cyc(N'($urandom & $urandom), ($urandom_range(3) != 0));
         rstn = 1'b1;
      end
      cyc('0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/assert_report_arbiter.md
Name: assert_report_arbiter

Overview:
- Collects one-cycle failure pulses from up to N_REQ bound assertion monitors attached to the same target module.
- Keeps a sticky pending bit per monitor and grants pending monitors in round-robin order.
- Sends one report at a time on a valid/ready port to a single shared report sink (logger/trace unit).
- Also keeps a saturating total-failure counter and a first-failure capture for end-of-test readout.

Parameters:
- N_REQ, 4, number of monitor failure inputs (2..16).
- ID_W, 2, width of a monitor index; must equal clog2(N_REQ).
- CNT_W, 16, width of the total failure counter.
- TS_W, 32, timestamp width; used only when the optional feature is compiled in.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESETN  input  1  reset; synchronous, active-low.
- fail_i  input  N_REQ  per-monitor failure pulse; each asserted bit is one failure event that cycle.
- rpt_valid  output  1  report available.
- rpt_ready  input  1  sink accepts the report; handshake completes when rpt_valid && rpt_ready.
- rpt_id  output  ID_W  index of the reporting monitor.
- rpt_overrun  output  1  one or more further failures of this monitor were merged into this report.
- pending  output  N_REQ  sticky pending bits (debug view).
- fail_count  output  CNT_W  total failure events since reset, saturating.
- first_valid  output  1  at least one failure has happened since reset.
- first_id  output  ID_W  index of the first failing monitor.

Behaviour:
- Reset (RESETN=0 at a CLK edge): all of the following go to 0 — rpt_valid, rpt_id, rpt_overrun, pending, overrun state, fail_count, first_valid, first_id — and the round-robin pointer is set to 0.
  - A reset during an outstanding report drops that report; no handshake is needed.
  - fail_i in the reset cycle is ignored.
- Request vector: req = pending | fail_i.
- Report slot is free when rpt_valid==0, or when a handshake completes this cycle.
- Grant rule: if the slot is free and req is nonzero, pick the first set bit of req searching from index ptr upward, wrapping modulo N_REQ. At the next edge:
  - rpt_valid=1, rpt_id=granted index g.
  - rpt_overrun = overrun[g] OR (pending[g] AND fail_i[g]).
  - overrun[g] cleared, pending[g] cleared, ptr=(g+1) mod N_REQ.
- Latency: from an idle slot, fail_i in cycle t gives rpt_valid in cycle t+1.
- Back-to-back: a handshake in cycle t followed by a nonempty req in cycle t gives a new report in t+1 with no bubble.
- Hold: while rpt_valid && !rpt_ready, rpt_id and rpt_overrun stay stable and ptr does not move.
- Pending update for each index i not granted this cycle:
  - pending[i] |= fail_i[i].
  - If pending[i] && fail_i[i], set overrun[i].
- Granted index with a fresh fail: if fail_i[g] is asserted in the grant cycle and pending[g] was already set, the new event stays pending (pending[g]=1 after the edge). If pending[g] was clear, the fail is consumed by the grant itself.
- Slot busy, no handshake: no grant; fail_i only updates pending and overrun.
- fail_count: adds popcount(fail_i) each cycle and saturates at 2^CNT_W-1; it never wraps.
- First failure capture: on the first cycle with fail_i!=0 while first_valid==0, set first_valid=1 and first_id = lowest set index. It is held until reset.
- All outputs are registered; there is no combinational path from fail_i or rpt_ready to any output.
- A handshake on the same edge as a deasserted rpt_valid is meaningless and is ignored (ready without valid has no effect).

Optional Feature:
- Macro: ASSERT_REPORT_ARBITER_TIMESTAMP_EN.
- Defined:
  - Adds a TS_W free-running cycle counter, reset to 0, incrementing every cycle and wrapping.
  - Adds output port rpt_ts (TS_W bits): the counter value from the cycle the granted failure was first recorded in pending, or the fail_i cycle for a direct grant.
  - One captured timestamp per index; a later merged fail (overrun) does not overwrite it.
  - rpt_ts is held with rpt_id while the report is stalled.
- Undefined: no counter, no rpt_ts port, and all other behaviour is identical.

Test Plan:
- Single fail, ready=1: fail_i=4'b0100 in cycle 5 -> rpt_valid=1, rpt_id=2, rpt_overrun=0 in cycle 6; fail_count=1; first_valid=1, first_id=2.
- Simultaneous fails, ready=1, ptr=0: fail_i=4'b1011 for one cycle -> rpt_id sequence 0,1,3 on consecutive cycles; fail_count=3; first_id=0; pending ends 0.
- Backpressure: fail_i=4'b0001 with ready=0 for 4 cycles -> rpt_id=0 held stable; fails repeated on bit0 during the stall -> after ready=1, a second report id=0 with rpt_overrun=1; fail_count=5.
- Round-robin fairness: bits 0 and 1 continuously asserted, ready=1 -> rpt_id alternates 0,1,0,1.
- Saturation: CNT_W=4, 20 single-bit fail pulses -> fail_count stops at 15.
- Reset mid-report: rpt_valid=1, ready=0, RESETN=0 for one cycle -> next cycle all outputs 0; with the macro defined, rpt_ts restarts from 0 on the next report.
